mem_channel_arbiter: RTL and testbench

//  Shares NUM_CHANNELS data-memory channels among NUM_CONSUMERS LSU requesters (all thread LSUs of all cores).

---
 rtl/mem_channel_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_channel_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_channel_arbiter.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS LSU requesters.
// Each channel owns one outstanding read or write, relaying the handshake back to its consumer.
module mem_channel_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_e;

  state_e               state_q [NUM_CHANNELS];
  state_e               state_d [NUM_CHANNELS];
  logic [IW-1:0]        cons_q  [NUM_CHANNELS];
  logic [IW-1:0]        cons_d  [NUM_CHANNELS];
  logic [IW-1:0]        ptr_q   [NUM_CHANNELS];
  logic [IW-1:0]        ptr_d   [NUM_CHANNELS];
  logic                 is_wr_q [NUM_CHANNELS];
  logic                 is_wr_d [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_d  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] data_q  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] data_d  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rdata_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] rdata_d [NUM_CONSUMERS];

  logic [NUM_CONSUMERS-1:0] claimed;
  logic [NUM_CONSUMERS-1:0] taken;
  logic                     found;
  int unsigned              k;

  always_comb begin
    state_d = state_q;
    cons_d  = cons_q;
    ptr_d   = ptr_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    claimed = '0;
    found   = 1'b0;
    k       = 0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (state_q[c] != IDLE) claimed[cons_q[c]] = 1'b1;
    end
    // Lower channels grant first; taken marks consumers already picked this cycle.
    taken = claimed;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      unique case (state_q[c])
        IDLE: begin
          for (int unsigned off = 0; off < NUM_CONSUMERS; off++) begin
            k = (int'(ptr_q[c]) + off) % NUM_CONSUMERS;
            if (!found && !taken[k] && (consumer_read_valid[k] || consumer_write_valid[k])) begin
              found      = 1'b1;
              taken[k]   = 1'b1;
              cons_d[c]  = IW'(k);
              ptr_d[c]   = IW'((k + 1) % NUM_CONSUMERS);
              is_wr_d[c] = !consumer_read_valid[k];
              addr_d[c]  = consumer_read_valid[k] ? consumer_read_address[k*ADDR_BITS +: ADDR_BITS]
                                                  : consumer_write_address[k*ADDR_BITS +: ADDR_BITS];
              data_d[c]  = consumer_write_data[k*DATA_BITS +: DATA_BITS];
              state_d[c] = consumer_read_valid[k] ? READ_WAIT : WRITE_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready[c]) begin
            rdata_d[cons_q[c]] = mem_read_data[c*DATA_BITS +: DATA_BITS];
            state_d[c]         = RELAY;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready[c]) state_d[c] = RELAY;
        end
        RELAY: begin
          if (is_wr_q[c] ? !consumer_write_valid[cons_q[c]] : !consumer_read_valid[cons_q[c]])
            state_d[c] = IDLE;
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_comb begin
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      mem_read_valid[c]                                = (state_q[c] == READ_WAIT);
      mem_write_valid[c]                               = (state_q[c] == WRITE_WAIT);
      mem_read_address[c*ADDR_BITS +: ADDR_BITS]       = addr_q[c];
      mem_write_address[c*ADDR_BITS +: ADDR_BITS]      = addr_q[c];
      mem_write_data[c*DATA_BITS +: DATA_BITS]         = data_q[c];
      if (state_q[c] == RELAY) begin
        if (is_wr_q[c]) consumer_write_ready[cons_q[c]] = 1'b1;
        else            consumer_read_ready[cons_q[c]]  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      consumer_read_data[i*DATA_BITS +: DATA_BITS] = rdata_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        cons_q[c]  <= '0;
        ptr_q[c]   <= '0;
        is_wr_q[c] <= 1'b0;
        addr_q[c]  <= '0;
        data_q[c]  <= '0;
      end
      for (int unsigned i = 0; i < NUM_CONSUMERS; i++) rdata_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cons_q  <= cons_d;
      ptr_q   <= ptr_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench: one-channel and two-channel arbiter instances driven with hand-computed vectors.
module tb_mem_channel_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 4 consumers, 1 channel
  logic [3:0]  a_rv = '0, a_wv = '0, a_rr, a_wr;
  logic [31:0] a_raddr = '0, a_waddr = '0, a_wdata = '0, a_rdata;
  logic [0:0]  a_mrv, a_mwv, a_mrr = '0, a_mwr = '0;
  logic [7:0]  a_mra, a_mwa, a_mwd, a_mrd = '0;

  // Instance B: 4 consumers, 2 channels
  logic [3:0]  b_rv = '0, b_wv = '0, b_rr, b_wr;
  logic [31:0] b_raddr = '0, b_waddr = '0, b_wdata = '0, b_rdata;
  logic [1:0]  b_mrv, b_mwv, b_mrr = '0, b_mwr = '0;
  logic [15:0] b_mra, b_mwa, b_mwd, b_mrd = '0;

  mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) u_dut_a (
    .clk(clk), .reset(rst_n),
    .consumer_read_valid(a_rv), .consumer_read_address(a_raddr),
    .consumer_read_ready(a_rr), .consumer_read_data(a_rdata),
    .consumer_write_valid(a_wv), .consumer_write_address(a_waddr),
    .consumer_write_data(a_wdata), .consumer_write_ready(a_wr),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
  );

  mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) u_dut_b (
    .clk(clk), .reset(rst_n),
    .consumer_read_valid(b_rv), .consumer_read_address(b_raddr),
    .consumer_read_ready(b_rr), .consumer_read_data(b_rdata),
    .consumer_write_valid(b_wv), .consumer_write_address(b_waddr),
    .consumer_write_data(b_wdata), .consumer_write_ready(b_wr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  // Rising edges of each consumer's read ready on instance A
  int rdy_cnt [4] = '{0, 0, 0, 0};
  logic [3:0] a_rr_prev = '0;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (a_rr[i] && !a_rr_prev[i]) rdy_cnt[i]++;
    a_rr_prev = a_rr;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for the read to reach memory, answers it, then completes the consumer handshake.
  task automatic a_serve_read(input int kk, input logic [7:0] addr, input logic [7:0] data);
    int n = 0;
    while (a_mrv !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("rd_grant", a_mrv, 1);
    check_eq("rd_addr", a_mra, addr);
    check_eq("rd_no_wr", a_mwv, 0);
    a_mrr = 1'b1;
    a_mrd = data;
    @(negedge clk);
    a_mrr = 1'b0;
    a_mrd = '0;
    check_eq("rd_ready", a_rr, 4'b0001 << kk);
    check_eq("rd_mrv_drop", a_mrv, 0);
    check_eq("rd_data", a_rdata[kk*8 +: 8], data);
    a_rv[kk] = 1'b0;
    @(negedge clk);
    check_eq("rd_ready_drop", a_rr, 0);
    check_eq("rd_data_hold", a_rdata[kk*8 +: 8], data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base [4];
    int n;
    @(negedge clk);
    check_eq("rst_mrv", a_mrv, 0);
    check_eq("rst_rr", a_rr, 0);
    check_eq("rst_rdata", a_rdata, 0);
    check_eq("rst_b_mwv", b_mwv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read with a 3-cycle memory latency
    a_rv[0] = 1'b1;
    a_raddr[7:0] = 8'h10;
    @(negedge clk);
    check_eq("t1_mrv_lat", a_mrv, 1);
    check_eq("t1_addr", a_mra, 8'h10);
    @(negedge clk);
    check_eq("t1_mrv_hold", a_mrv, 1);
    @(negedge clk);
    a_mrr = 1'b1;
    a_mrd = 8'h5A;
    @(negedge clk);
    a_mrr = 1'b0;
    a_mrd = '0;
    check_eq("t1_ready", a_rr, 4'b0001);
    check_eq("t1_data", a_rdata[7:0], 8'h5A);
    check_eq("t1_mrv_drop", a_mrv, 0);
    @(negedge clk);
    check_eq("t1_ready_held", a_rr, 4'b0001);
    a_rv[0] = 1'b0;
    @(negedge clk);
    check_eq("t1_ready_drop", a_rr, 0);
    check_eq("t1_data_hold", a_rdata[7:0], 8'h5A);

    // All four read at once after a fresh reset
    pulse_reset();
    for (int i = 0; i < 4; i++) base[i] = rdy_cnt[i];
    a_raddr = 32'h33323130;
    a_rv = 4'hF;
    a_serve_read(0, 8'h30, 8'hA0);
    a_serve_read(1, 8'h31, 8'hA1);
    a_serve_read(2, 8'h32, 8'hA2);
    a_serve_read(3, 8'h33, 8'hA3);
    for (int i = 0; i < 4; i++) check_eq("t2_ready_once", rdy_cnt[i] - base[i], 1);

    // Pointer wraps after consumer 3
    a_raddr = 32'h43000040;
    a_rv = 4'b1001;
    a_serve_read(0, 8'h40, 8'hB0);
    a_serve_read(3, 8'h43, 8'hB3);

    // Read wins over write on the same consumer; write follows once read completes
    a_raddr[15:8] = 8'h51;
    a_waddr[15:8] = 8'h61;
    a_wdata[15:8] = 8'h77;
    a_rv[1] = 1'b1;
    a_wv[1] = 1'b1;
    a_serve_read(1, 8'h51, 8'hC1);
    n = 0;
    while (a_mwv !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("wr_grant", a_mwv, 1);
    check_eq("wr_addr", a_mwa, 8'h61);
    check_eq("wr_data", a_mwd, 8'h77);
    check_eq("wr_no_rd", a_mrv, 0);
    a_mwr = 1'b1;
    @(negedge clk);
    a_mwr = 1'b0;
    check_eq("wr_ready", a_wr, 4'b0010);
    check_eq("wr_mwv_drop", a_mwv, 0);
    a_wv[1] = 1'b0;
    @(negedge clk);
    check_eq("wr_ready_drop", a_wr, 0);

    // Spurious memory ready while idle
    a_mrr = 1'b1;
    a_mrd = 8'hEE;
    @(negedge clk);
    @(negedge clk);
    check_eq("sp_rr", a_rr, 0);
    check_eq("sp_mrv", a_mrv, 0);
    check_eq("sp_data", a_rdata[15:8], 8'hC1);
    a_mrr = 1'b0;
    a_mrd = '0;

    // Reset during READ_WAIT; pointer must restart at consumer 0
    a_raddr = 32'h73720000;
    a_rv[2] = 1'b1;
    @(negedge clk);
    check_eq("rw_mrv", a_mrv, 1);
    check_eq("rw_addr", a_mra, 8'h72);
    rst_n = 1'b0;
    #1;
    check_eq("rw_rst_mrv", a_mrv, 0);
    check_eq("rw_rst_rr", a_rr, 0);
    check_eq("rw_rst_rdata", a_rdata, 0);
    a_rv[3] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    a_serve_read(2, 8'h72, 8'hD2);
    a_serve_read(3, 8'h73, 8'hD3);

    // Two channels, two simultaneous writes
    b_waddr = 32'h00002120;
    b_wdata = 32'h00002211;
    b_wv = 4'b0011;
    @(negedge clk);
    check_eq("b_mwv", b_mwv, 2'b11);
    check_eq("b_mwa", b_mwa, 16'h2120);
    check_eq("b_mwd", b_mwd, 16'h2211);
    check_eq("b_mrv", b_mrv, 0);
    check_eq("b_wr_idle", b_wr, 0);
    b_mwr = 2'b11;
    @(negedge clk);
    b_mwr = 2'b00;
    check_eq("b_wr", b_wr, 4'b0011);
    check_eq("b_mwv_drop", b_mwv, 0);
    b_wv = 4'b0000;
    @(negedge clk);
    check_eq("b_wr_drop", b_wr, 0);
    b_waddr[15:8] = 8'h29;
    b_wv = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    check_eq("b_ch0_regrant", b_mwv, 2'b01);
    check_eq("b_ch0_addr", b_mwa[7:0], 8'h29);
    b_mwr = 2'b01;
    @(negedge clk);
    b_mwr = 2'b00;
    check_eq("b_wr2", b_wr, 4'b0010);
    b_wv = 4'b0000;
    @(negedge clk);
    check_eq("b_wr2_drop", b_wr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
